// File: rtl/serial_cmd_initiator_pkg.sv
// rtl/serial_cmd_initiator_pkg.sv - opcodes, FSM states and response sizes for the serial command initiator
package serial_cmd_initiator_pkg;

    localparam logic [7:0] OP_VERSION     = 8'd0;
    localparam logic [7:0] OP_DEADTICKS   = 8'd1;
    localparam logic [7:0] OP_FIRINGTICKS = 8'd2;
    localparam logic [7:0] OP_TOG_OUT     = 8'd3;
    localparam logic [7:0] OP_TOG_CLK     = 8'd4;
    localparam logic [7:0] OP_PLL_PHASE   = 8'd5;
    localparam logic [7:0] OP_MASK1       = 8'd6;
    localparam logic [7:0] OP_MASK2       = 8'd7;
    localparam logic [7:0] OP_PASSTHRU    = 8'd8;
    localparam logic [7:0] OP_HISTO       = 8'd10;
    localparam logic [7:0] OP_TOG_VETO    = 8'd11;
    localparam logic [7:0] OP_PLL_RESET   = 8'd13;
    localparam logic [7:0] OP_VETO_CYC    = 8'd14;
    localparam logic [7:0] OP_CLK_AS_IN   = 8'd15;

    localparam int HISTO_RESP_BYTES   = 288;
    localparam int VERSION_RESP_BYTES = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_WAIT_OP,
        ST_SEND_ARG,
        ST_WAIT_ARG,
        ST_DRAIN,
        ST_RECV
    } state_e;

endpackage

// File: rtl/resp_word_packer.sv
// rtl/resp_word_packer.sv - assembles response bytes into little-endian 32-bit words
module resp_word_packer #(
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic [IDX_W-1:0] byte_idx,
    output logic             word_valid,
    output logic [31:0]      word_data,
    output logic [IDX_W-3:0] word_idx
);

    logic [23:0]      acc_q, acc_d;
    logic             word_valid_q, word_valid_d;
    logic [31:0]      word_data_q, word_data_d;
    logic [IDX_W-3:0] word_idx_q, word_idx_d;

    // The top byte of a word is never stored; it completes the word directly.
    always_comb begin
        acc_d        = acc_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        word_idx_d   = word_idx_q;
        if (clear) begin
            acc_d = '0;
        end else if (byte_valid) begin
            case (byte_idx[1:0])
                2'd0:    acc_d[7:0]   = byte_data;
                2'd1:    acc_d[15:8]  = byte_data;
                2'd2:    acc_d[23:16] = byte_data;
                default: begin
                    word_valid_d = 1'b1;
                    word_data_d  = {byte_data, acc_q};
                    word_idx_d   = byte_idx[IDX_W-1:2];
                    acc_d        = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_idx_q   <= '0;
        end else begin
            acc_q        <= acc_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_idx_q   <= word_idx_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_idx   = word_idx_q;

endmodule

// File: rtl/serial_cmd_initiator.sv
// rtl/serial_cmd_initiator.sv - host side of the byte-serial command protocol over a UART
module serial_cmd_initiator
    import serial_cmd_initiator_pkg::*;
#(
    parameter int MAX_RESP_BYTES = 288,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int IDX_W          = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_opcode,
    input  logic             cmd_has_arg,
    input  logic [7:0]       cmd_arg,
    input  logic [IDX_W-1:0] cmd_resp_len,
    input  logic             txBusy,
    output logic             txStart,
    output logic [7:0]       txData,
    input  logic             rxReady,
    input  logic [7:0]       rxData,
    output logic             resp_byte_valid,
    output logic [7:0]       resp_byte,
    output logic [IDX_W-1:0] resp_byte_idx,
    output logic             word_valid,
    output logic [31:0]      word_data,
    output logic [IDX_W-3:0] word_idx,
    output logic             done,
    output logic             timeout,
    output logic             rx_stray
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] MAX_LEN  = IDX_W'(MAX_RESP_BYTES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    state_e           state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [7:0]       arg_q, arg_d;
    logic             has_arg_q, has_arg_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             resp_byte_valid_q, resp_byte_valid_d;
    logic [7:0]       resp_byte_q, resp_byte_d;
    logic [IDX_W-1:0] resp_byte_idx_q, resp_byte_idx_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             rx_stray_q, rx_stray_d;

    logic             accept;

    assign accept = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = ST_SEND_OP;
            ST_SEND_OP:  if (!txBusy) state_d = ST_WAIT_OP;
            ST_WAIT_OP:  state_d = has_arg_q ? ST_SEND_ARG : ST_DRAIN;
            ST_SEND_ARG: if (!txBusy) state_d = ST_WAIT_ARG;
            ST_WAIT_ARG: state_d = ST_DRAIN;
            ST_DRAIN:    if (!txBusy) state_d = (len_q == '0) ? ST_IDLE : ST_RECV;
            ST_RECV: begin
                if (count_q == len_q)                  state_d = ST_IDLE;
                else if (!rxReady && timer_q <= TMR_ONE) state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        opcode_d          = opcode_q;
        arg_d             = arg_q;
        has_arg_d         = has_arg_q;
        len_d             = len_q;
        count_d           = count_q;
        timer_d           = timer_q;
        cmd_ready_d       = (state_q == ST_IDLE) && !accept;
        tx_start_d        = 1'b0;
        tx_data_d         = tx_data_q;
        resp_byte_valid_d = 1'b0;
        resp_byte_d       = resp_byte_q;
        resp_byte_idx_d   = resp_byte_idx_q;
        done_d            = 1'b0;
        timeout_d         = 1'b0;
        rx_stray_d        = rxReady && (state_q != ST_RECV);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    opcode_d  = cmd_opcode;
                    arg_d     = cmd_arg;
                    has_arg_d = cmd_has_arg;
                    len_d     = (cmd_resp_len > MAX_LEN) ? MAX_LEN : cmd_resp_len;
                    count_d   = '0;
                end
            end
            ST_SEND_OP: begin
                if (!txBusy) begin
                    tx_data_d  = opcode_q;
                    tx_start_d = 1'b1;
                end
            end
            ST_SEND_ARG: begin
                if (!txBusy) begin
                    tx_data_d  = arg_q;
                    tx_start_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!txBusy) begin
                    if (len_q == '0) done_d  = 1'b1;
                    else             timer_d = TMR_LOAD;
                end
            end
            ST_RECV: begin
                // A byte arriving in the expiry cycle still counts and restarts the timer.
                if (count_q == len_q) begin
                    done_d = 1'b1;
                end else if (rxReady) begin
                    resp_byte_valid_d = 1'b1;
                    resp_byte_d       = rxData;
                    resp_byte_idx_d   = count_q;
                    count_d           = count_q + 1'b1;
                    timer_d           = TMR_LOAD;
                end else if (timer_q <= TMR_ONE) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q          <= '0;
            arg_q             <= '0;
            has_arg_q         <= 1'b0;
            len_q             <= '0;
            count_q           <= '0;
            timer_q           <= '0;
            cmd_ready_q       <= 1'b0;
            tx_start_q        <= 1'b0;
            tx_data_q         <= '0;
            resp_byte_valid_q <= 1'b0;
            resp_byte_q       <= '0;
            resp_byte_idx_q   <= '0;
            done_q            <= 1'b0;
            timeout_q         <= 1'b0;
            rx_stray_q        <= 1'b0;
        end else begin
            opcode_q          <= opcode_d;
            arg_q             <= arg_d;
            has_arg_q         <= has_arg_d;
            len_q             <= len_d;
            count_q           <= count_d;
            timer_q           <= timer_d;
            cmd_ready_q       <= cmd_ready_d;
            tx_start_q        <= tx_start_d;
            tx_data_q         <= tx_data_d;
            resp_byte_valid_q <= resp_byte_valid_d;
            resp_byte_q       <= resp_byte_d;
            resp_byte_idx_q   <= resp_byte_idx_d;
            done_q            <= done_d;
            timeout_q         <= timeout_d;
            rx_stray_q        <= rx_stray_d;
        end
    end

    resp_word_packer #(
        .IDX_W(IDX_W)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .byte_valid (resp_byte_valid_q),
        .byte_data  (resp_byte_q),
        .byte_idx   (resp_byte_idx_q),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_idx   (word_idx)
    );

    assign cmd_ready       = cmd_ready_q;
    assign txStart         = tx_start_q;
    assign txData          = tx_data_q;
    assign resp_byte_valid = resp_byte_valid_q;
    assign resp_byte       = resp_byte_q;
    assign resp_byte_idx   = resp_byte_idx_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign rx_stray        = rx_stray_q;

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// tb/tb_serial_cmd_initiator.sv - randomized self-checking bench for serial_cmd_initiator
module tb_serial_cmd_initiator;
    import serial_cmd_initiator_pkg::*;

    localparam int IW   = 9;
    localparam int MAXB = 288;
    localparam int TMO  = 200;

    logic          clk, reset;
    logic          cmd_valid, cmd_ready, cmd_has_arg;
    logic [7:0]    cmd_opcode, cmd_arg;
    logic [IW-1:0] cmd_resp_len;
    logic          txBusy, txStart;
    logic [7:0]    txData;
    logic          rxReady;
    logic [7:0]    rxData;
    logic          resp_byte_valid;
    logic [7:0]    resp_byte;
    logic [IW-1:0] resp_byte_idx;
    logic          word_valid;
    logic [31:0]   word_data;
    logic [IW-3:0] word_idx;
    logic          done, timeout, rx_stray;

    serial_cmd_initiator #(
        .MAX_RESP_BYTES(MAXB),
        .TIMEOUT_CYCLES(TMO),
        .IDX_W(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg), .cmd_resp_len(cmd_resp_len),
        .txBusy(txBusy), .txStart(txStart), .txData(txData),
        .rxReady(rxReady), .rxData(rxData),
        .resp_byte_valid(resp_byte_valid), .resp_byte(resp_byte), .resp_byte_idx(resp_byte_idx),
        .word_valid(word_valid), .word_data(word_data), .word_idx(word_idx),
        .done(done), .timeout(timeout), .rx_stray(rx_stray)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  rb_q[$];
    int          ri_q[$];
    int          rc_q[$];
    logic [31:0] wd_q[$];
    int          wi_q[$];
    int          wc_q[$];
    int          first_tx_cyc, done_cnt, timeout_cnt, stray_cnt, done_cyc;
    int          last_byte_cyc, busy_fall_cyc, busy_left;
    bit          force_busy = 0;
    bit          done_prev, prev_busy;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor plus UART transmitter model: busy for a random spell after each send.
    initial begin
        txBusy    = 0;
        busy_left = 0;
        done_prev = 0;
        forever begin
            @(negedge clk);
            if (txStart) begin
                check("tx_not_busy", txBusy, 0);
                tx_q.push_back(txData);
                if (tx_q.size() == 1) first_tx_cyc = cyc;
                busy_left = $urandom_range(2, 6);
            end else if (busy_left > 0) begin
                busy_left--;
            end
            prev_busy = txBusy;
            txBusy    = force_busy || (busy_left > 0);
            if (prev_busy && !txBusy) busy_fall_cyc = cyc;
            if (resp_byte_valid) begin
                rb_q.push_back(resp_byte);
                ri_q.push_back(int'(resp_byte_idx));
                rc_q.push_back(cyc);
                last_byte_cyc = cyc;
            end
            if (word_valid) begin
                wd_q.push_back(word_data);
                wi_q.push_back(int'(word_idx));
                wc_q.push_back(cyc);
            end
            if (done_prev) check("ready_after_done", cmd_ready, 1);
            done_prev = done;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (timeout) timeout_cnt++;
            if (rx_stray) stray_cnt++;
        end
    end

    task automatic clear_mon();
        tx_q.delete(); rb_q.delete(); ri_q.delete(); rc_q.delete();
        wd_q.delete(); wi_q.delete(); wc_q.delete();
        first_tx_cyc = -1; done_cnt = 0; timeout_cnt = 0; stray_cnt = 0;
        done_cyc = -1; last_byte_cyc = -1;
    endtask

    task automatic reset_and_check();
        reset = 1;
        tick();
        tick();
        check("rst_word_data", word_data, 0);
        check("rst_ctrl", {cmd_ready, txStart, txData, resp_byte_valid, resp_byte, resp_byte_idx,
                           word_valid, word_idx, done, timeout, rx_stray}, 0);
        reset = 0;
        tick();
        check("ready_after_rst", cmd_ready, 1);
    endtask

    // pat: <0 ramp (i mod 256), 0..255 constant, >255 random bytes; abort_at>0 resets after that many bytes
    task automatic run_cmd(input logic [7:0] op, input bit has_arg, input logic [7:0] arg,
                           input int len, input int nsend, input int max_gap,
                           input bit hold, input int abort_at, input int pat);
        logic [7:0] sent[$];
        int eff, got, ntx, b, accept_cyc, rel_fall;
        logic [31:0] w;
        eff = (len > MAXB) ? MAXB : len;
        got = (nsend < eff) ? nsend : eff;
        ntx = has_arg ? 2 : 1;
        for (int i = 0; i < nsend; i++) begin
            if (pat < 0)        sent.push_back(8'(i));
            else if (pat > 255) sent.push_back(8'($urandom));
            else                sent.push_back(8'(pat));
        end
        clear_mon();
        if (hold) begin
            force_busy = 1;
            tick();
        end
        b = 0;
        while (!cmd_ready && b < 2000) begin tick(); b++; end
        check("ready_wait", cmd_ready, 1);
        cmd_opcode = op; cmd_has_arg = has_arg; cmd_arg = arg; cmd_resp_len = IW'(len);
        cmd_valid = 1; accept_cyc = cyc;
        tick();
        cmd_valid = 0; cmd_opcode = 8'($urandom); cmd_arg = 8'($urandom);
        rel_fall = -1;
        if (hold) begin
            repeat (50) tick();
            check("no_tx_while_held", tx_q.size(), 0);
            force_busy = 0;
            tick();
            rel_fall = busy_fall_cyc;
        end
        b = 0;
        while (!(tx_q.size() >= ntx && !txBusy) && b < 500) begin tick(); b++; end
        check("tx_count", tx_q.size(), ntx);
        if (tx_q.size() >= 1) check("tx_opcode", tx_q[0], op);
        if (has_arg && tx_q.size() >= 2) check("tx_arg", tx_q[1], arg);
        if (hold) check("first_tx_after_release", first_tx_cyc, rel_fall + 1);
        else      check("first_tx_latency", first_tx_cyc, accept_cyc + 2);
        tick();
        foreach (sent[i]) begin
            repeat ($urandom_range(0, max_gap)) tick();
            rxData = sent[i]; rxReady = 1;
            tick();
            rxReady = 0;
            if (abort_at == i + 1) begin
                tick();
                reset_and_check();
                check("abort_no_done", done_cnt, 0);
                return;
            end
        end
        b = 0;
        while (done_cnt == 0 && b < TMO + 500) begin tick(); b++; end
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("timeout_flag", timeout_cnt, (got < eff) ? 1 : 0);
        check("stray_none", stray_cnt, 0);
        check("resp_count", rb_q.size(), got);
        for (int i = 0; i < got && i < rb_q.size(); i++) begin
            check($sformatf("resp_byte[%0d]", i), rb_q[i], sent[i]);
            check($sformatf("resp_idx[%0d]", i), ri_q[i], i);
        end
        check("word_count", wd_q.size(), got / 4);
        for (int k = 0; k < got / 4 && k < wd_q.size(); k++) begin
            w = {sent[4*k+3], sent[4*k+2], sent[4*k+1], sent[4*k]};
            check($sformatf("word_data[%0d]", k), wd_q[k], w);
            check($sformatf("word_idx[%0d]", k), wi_q[k], k);
            if (4*k+3 < rc_q.size()) check($sformatf("word_cyc[%0d]", k), wc_q[k], rc_q[4*k+3] + 1);
        end
        if (eff == 0)                 check("done_after_drain", done_cyc, busy_fall_cyc + 1);
        else if (got == eff)          check("done_after_last", done_cyc, last_byte_cyc + 1);
        else if (got > 0)             check("timeout_latency", done_cyc - last_byte_cyc, TMO);
    endtask

    initial begin
        int len, ns;
        reset = 1; cmd_valid = 0; cmd_opcode = 0; cmd_has_arg = 0; cmd_arg = 0;
        cmd_resp_len = 0; rxReady = 0; rxData = 0;
        clear_mon();
        tick();
        reset_and_check();

        run_cmd(OP_VERSION, 0, 8'h00, VERSION_RESP_BYTES, 1, 3, 0, 0, 8'h16);
        run_cmd(OP_DEADTICKS, 1, 8'h0A, 0, 0, 3, 0, 0, 256);
        run_cmd(OP_HISTO, 0, 8'h00, HISTO_RESP_BYTES, HISTO_RESP_BYTES, 2, 0, 0, -1);
        if (wd_q.size() == 72) begin
            check("histo_word0", wd_q[0], 32'h03020100);
            check("histo_word71", wd_q[71], 32'h1F1E1D1C);
        end
        run_cmd(OP_MASK1, 0, 8'h00, 4, 2, 3, 0, 0, 256);
        run_cmd(OP_PASSTHRU, 1, 8'h33, 2, 2, 3, 1, 0, 256);

        clear_mon();
        rxData = 8'h5A; rxReady = 1;
        tick();
        rxReady = 0;
        repeat (2) tick();
        check("stray_in_idle", stray_cnt, 1);
        check("stray_no_resp", rb_q.size(), 0);

        run_cmd(OP_HISTO, 0, 8'h00, 300, MAXB, 1, 0, 0, 256);

        for (int t = 0; t < 10; t++) begin
            len = $urandom_range(0, 20);
            ns  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
            run_cmd(8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom),
                    len, ns, 4, 1'($urandom_range(0, 5) == 0), 0, 256);
        end

        run_cmd(OP_HISTO, 0, 8'h00, HISTO_RESP_BYTES, HISTO_RESP_BYTES, 2, 0, 100, -1);
        run_cmd(OP_VERSION, 0, 8'h00, VERSION_RESP_BYTES, 1, 3, 0, 0, 8'h16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_cmd_initiator.md
Name: serial_cmd_initiator

Overview:
- Host side of the board's byte-serial command protocol: opcode byte, optional 1-byte argument, then a fixed-length response.
- Lets one board configure and read back another board over a UART link, or lets the bench exercise a board with the same protocol.
- Drives a UART transmitter (txStart/txBusy/txData) and consumes a UART receiver (rxReady/rxData).
- Delivers response bytes, plus little-endian 32-bit words for histogram readback.

Parameters:
- MAX_RESP_BYTES, 288, maximum response length accepted; larger requests are clamped.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed before the first response byte, and between consecutive response bytes.
- IDX_W, 9, width of the byte index; must satisfy 2^IDX_W > MAX_RESP_BYTES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, can accept a command
- cmd_opcode  in  8  opcode byte
- cmd_has_arg  in  1  send cmd_arg after the opcode
- cmd_arg  in  8  argument byte
- cmd_resp_len  in  IDX_W  expected response bytes (0..MAX_RESP_BYTES)
- txBusy  in  1  UART transmitter busy
- txStart  out  1  one-cycle send strobe
- txData  out  8  byte to send
- rxReady  in  1  one-cycle strobe: rxData valid
- rxData  in  8  received byte
- resp_byte_valid  out  1  one-cycle strobe per response byte
- resp_byte  out  8  response byte
- resp_byte_idx  out  IDX_W  0-based byte index
- word_valid  out  1  one-cycle strobe per completed 32-bit word
- word_data  out  32  little-endian assembled word
- word_idx  out  IDX_W-2  0-based word index
- done  out  1  one-cycle strobe at command end
- timeout  out  1  one-cycle strobe, coincident with done, on timeout
- rx_stray  out  1  one-cycle strobe: rxReady arrived outside RECV

Behaviour:
Reset and outputs:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0. cmd_ready rises the first cycle after reset deasserts.
- Reset mid-operation aborts immediately: no done, no further txStart, packer cleared, state IDLE.

State machine: IDLE, SEND_OP, WAIT_OP, SEND_ARG, WAIT_ARG, DRAIN, RECV.
- IDLE: cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch opcode, arg, has_arg and len = min(cmd_resp_len, MAX_RESP_BYTES).
  - Clear the byte counter and packer. Drop cmd_ready. Go to SEND_OP.
- SEND_OP: when !txBusy, txData<=opcode, txStart<=1 (single cycle), go to WAIT_OP.
  - Earliest txStart is acceptance cycle +2.
- WAIT_OP: one cycle, so the UART can raise txBusy. Then go to SEND_ARG if has_arg, else to DRAIN.
- SEND_ARG/WAIT_ARG: same as SEND_OP/WAIT_OP with arg, then go to DRAIN.
- DRAIN: wait for !txBusy.
  - If len==0: done=1, go to IDLE.
  - Else: load timer=TIMEOUT_CYCLES, go to RECV.
- RECV: on rxReady, output resp_byte<=rxData, resp_byte_idx<=count, resp_byte_valid<=1, count++, reload timer.
  - When count reaches len, done=1 on the cycle after the last resp_byte_valid, go to IDLE.
  - Without rxReady, timer decrements. At 0: timeout=1, done=1, go to IDLE.
  - rxReady in the expiry cycle wins: byte taken, no timeout.

Other rules:
- rxReady in any state other than RECV: byte discarded, rx_stray=1.
- New commands are ignored until cmd_ready returns; cmd_ready rises the cycle after done.
- Packer:
  - Byte 4k+j goes to bits [8j+7:8j].
  - word_valid is asserted the cycle after the resp_byte_valid of byte 4k+3, with word_idx=k.
  - A trailing partial word (len not a multiple of 4) is discarded at done.

Decomposition:
- Shared package: opcode constants (VERSION=0, DEADTICKS=1, FIRINGTICKS=2, TOG_OUT=3, TOG_CLK=4, PLL_PHASE=5, MASK1=6, MASK2=7, PASSTHRU=8, HISTO=10, TOG_VETO=11, PLL_RESET=13, VETO_CYC=14, CLK_AS_IN=15), the state enum, HISTO_RESP_BYTES=288, VERSION_RESP_BYTES=1.
- One sub-module, resp_word_packer: byte strobe/index in, word strobe/data/index out, clear input.

Test Plan:
- Opcode 0x00, no arg, len 1; the UART model replies 0x16 → one txStart with txData=0x00; resp_byte=0x16 at idx 0; done; timeout=0; no word_valid.
- Opcode 0x01, arg 0x0A, len 0 → txStart with 0x01, then txStart with 0x0A only after txBusy falls; done after the final txBusy low; no resp_byte_valid.
- Opcode 0x0A, len 288; model sends byte i = i mod 256 → 288 byte strobes, 72 word_valid; word0=0x03020100, word71=0x1F1E1D1C; done once.
- Len 4; model sends 2 bytes then stops → timeout+done exactly TIMEOUT_CYCLES cycles after byte 1's strobe; no word_valid; cmd_ready back next cycle.
- txBusy held high 50 cycles after acceptance → no txStart until release; rxReady pulse in IDLE → rx_stray=1, no resp_byte_valid.
- Reset asserted mid-RECV of the 288-byte command → no done; cmd_ready=1 after release; a following version command completes normally.
